// File: rtl/fifo_checker.sv
// fifo_checker: scoreboard monitor for FIFO-like DUTs. Keeps a per-channel
// expected-data queue fed by push events and checked against pop events,
// with saturating statistics counters and sticky error flags.
// Optional first-mismatch capture outputs: define FIFO_CHECKER_CAPTURE_EN.
module fifo_checker #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int N_CHAN = 1,
  parameter int CNT_W  = 32,
  localparam int CHAN_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic [N_CHAN-1:0]        i_push,
  input  logic [N_CHAN*WIDTH-1:0]  i_pushData,
  input  logic [N_CHAN-1:0]        i_pop,
  input  logic [N_CHAN*WIDTH-1:0]  i_popData,
  input  logic                     i_drainCheck,
  output logic [CNT_W-1:0]         o_nPushed,
  output logic [CNT_W-1:0]         o_nPopped,
  output logic [CNT_W-1:0]         o_nMismatch,
  output logic [N_CHAN-1:0]        o_errOverflow,
  output logic [N_CHAN-1:0]        o_errUnderflow,
  output logic [N_CHAN-1:0]        o_errMismatch,
  output logic [N_CHAN-1:0]        o_errDrain,
  output logic                     o_err
`ifdef FIFO_CHECKER_CAPTURE_EN
  ,
  output logic                     o_capValid,
  output logic [CHAN_W-1:0]        o_capChan,
  output logic [WIDTH-1:0]         o_capExpected,
  output logic [WIDTH-1:0]         o_capGot
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int INC_W = 4;  // holds up to 8 same-cycle events

  // Saturating add of a small per-cycle increment onto a statistics counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W + 1 - INC_W){1'b0}}, b};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic [WIDTH-1:0] mem_r    [N_CHAN][DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [N_CHAN];
  logic [PTR_W-1:0] rd_ptr_r [N_CHAN];
  logic [OCC_W-1:0] occ_r    [N_CHAN];

  logic [CNT_W-1:0]  n_pushed_r, n_popped_r, n_mismatch_r;
  logic [N_CHAN-1:0] err_ov_r, err_uf_r, err_mm_r, err_dr_r;
  logic              err_r;

  logic [WIDTH-1:0]  head_s [N_CHAN];
  logic [N_CHAN-1:0] push_ok_s, pop_ok_s, ov_s, uf_s, mm_s, dr_s;
  logic [INC_W-1:0]  n_push_s, n_pop_s, n_mm_s;

  // Per-channel event qualification and per-cycle event totals.
  always_comb begin
    push_ok_s = '0;
    pop_ok_s  = '0;
    ov_s      = '0;
    uf_s      = '0;
    mm_s      = '0;
    dr_s      = '0;
    n_push_s  = '0;
    n_pop_s   = '0;
    n_mm_s    = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      head_s[c] = mem_r[c][rd_ptr_r[c]];
      // Pop against a non-empty queue; an empty queue never pops, even with a
      // same-cycle push, so the pushed entry is only checkable next cycle.
      pop_ok_s[c]  = i_cg & i_pop[c] & (occ_r[c] != OCC_W'(0));
      uf_s[c]      = i_cg & i_pop[c] & (occ_r[c] == OCC_W'(0));
      // A full queue still accepts a push when a pop frees a slot this cycle.
      push_ok_s[c] = i_cg & i_push[c] & ((occ_r[c] != OCC_W'(DEPTH)) | pop_ok_s[c]);
      ov_s[c]      = i_cg & i_push[c] & (occ_r[c] == OCC_W'(DEPTH)) & ~pop_ok_s[c];
      mm_s[c]      = pop_ok_s[c] & (i_popData[c*WIDTH +: WIDTH] != head_s[c]);
      // Drain check looks at occupancy before this cycle's push/pop.
      dr_s[c]      = i_cg & i_drainCheck & (occ_r[c] != OCC_W'(0));
      n_push_s     = n_push_s + INC_W'(push_ok_s[c]);
      n_pop_s      = n_pop_s + INC_W'(pop_ok_s[c]);
      n_mm_s       = n_mm_s + INC_W'(mm_s[c]);
    end
  end

  // Expected-data storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < N_CHAN; c++) begin
      if (push_ok_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= i_pushData[c*WIDTH +: WIDTH];
      end
    end
  end

  // Queue pointers, occupancy, counters and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < N_CHAN; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        occ_r[c]    <= '0;
      end
      n_pushed_r   <= '0;
      n_popped_r   <= '0;
      n_mismatch_r <= '0;
      err_ov_r     <= '0;
      err_uf_r     <= '0;
      err_mm_r     <= '0;
      err_dr_r     <= '0;
      err_r        <= 1'b0;
    end else if (i_cg) begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (push_ok_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
        end
        if (pop_ok_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
        end
        case ({push_ok_s[c], pop_ok_s[c]})
          2'b10:   occ_r[c] <= occ_r[c] + OCC_W'(1);
          2'b01:   occ_r[c] <= occ_r[c] - OCC_W'(1);
          default: occ_r[c] <= occ_r[c];
        endcase
      end
      n_pushed_r   <= sat_add(n_pushed_r, n_push_s);
      n_popped_r   <= sat_add(n_popped_r, n_pop_s);
      n_mismatch_r <= sat_add(n_mismatch_r, n_mm_s);
      err_ov_r     <= err_ov_r | ov_s;
      err_uf_r     <= err_uf_r | uf_s;
      err_mm_r     <= err_mm_r | mm_s;
      err_dr_r     <= err_dr_r | dr_s;
      err_r        <= |{err_ov_r, ov_s, err_uf_r, uf_s, err_mm_r, mm_s, err_dr_r, dr_s};
    end
  end

  assign o_nPushed      = n_pushed_r;
  assign o_nPopped      = n_popped_r;
  assign o_nMismatch    = n_mismatch_r;
  assign o_errOverflow  = err_ov_r;
  assign o_errUnderflow = err_uf_r;
  assign o_errMismatch  = err_mm_r;
  assign o_errDrain     = err_dr_r;
  assign o_err          = err_r;

`ifdef FIFO_CHECKER_CAPTURE_EN
  logic              cap_valid_r;
  logic [CHAN_W-1:0] cap_chan_r;
  logic [WIDTH-1:0]  cap_exp_r, cap_got_r;
  logic [CHAN_W-1:0] cap_chan_s;
  logic [WIDTH-1:0]  cap_exp_s, cap_got_s;

  // Pick the lowest mismatching channel: scan downwards so lower wins.
  always_comb begin
    cap_chan_s = '0;
    cap_exp_s  = '0;
    cap_got_s  = '0;
    for (int c = N_CHAN - 1; c >= 0; c--) begin
      cap_chan_s = mm_s[c] ? CHAN_W'(c) : cap_chan_s;
      cap_exp_s  = mm_s[c] ? head_s[c] : cap_exp_s;
      cap_got_s  = mm_s[c] ? i_popData[c*WIDTH +: WIDTH] : cap_got_s;
    end
  end

  // Latch the first mismatch after reset and hold it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_valid_r <= 1'b0;
      cap_chan_r  <= '0;
      cap_exp_r   <= '0;
      cap_got_r   <= '0;
    end else if (i_cg && !cap_valid_r && (|mm_s)) begin
      cap_valid_r <= 1'b1;
      cap_chan_r  <= cap_chan_s;
      cap_exp_r   <= cap_exp_s;
      cap_got_r   <= cap_got_s;
    end
  end

  assign o_capValid    = cap_valid_r;
  assign o_capChan     = cap_chan_r;
  assign o_capExpected = cap_exp_r;
  assign o_capGot      = cap_got_r;
`endif

endmodule
